// File: rtl/echo_pkg.sv
// Shared types and constants for the echo engine.
package echo_pkg;

  typedef enum logic [1:0] {
    RECV = 2'd0,
    EMIT = 2'd1,
    REQ  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [1:0] MODE_PLAIN = 2'd0;
  localparam logic [1:0] MODE_UPPER = 2'd1;
  localparam logic [1:0] MODE_REV   = 2'd2;

  localparam logic [7:0] NUL        = 8'h00;
  localparam logic [7:0] COLON      = 8'h3A;
  localparam logic [7:0] DIGIT0     = 8'h30;
  localparam logic [7:0] LOWER_A    = 8'h61;
  localparam logic [7:0] LOWER_Z    = 8'h7A;
  localparam logic [7:0] CASE_DELTA = 8'h20;

  localparam int unsigned LINE_CNT_W = 4;

endpackage

// File: rtl/echo_char_xform.sv
// Combinational lower-to-upper case mapping; non-letters pass through.
module echo_char_xform
  import echo_pkg::*;
(
  input  logic       upper_en_i,
  input  logic [7:0] char_i,
  output logic [7:0] char_c_o
);

  always_comb begin
    char_c_o = char_i;
    if (upper_en_i && (char_i >= LOWER_A) && (char_i <= LOWER_Z)) begin
      char_c_o = char_i - CASE_DELTA;
    end
  end

endmodule

// File: rtl/echo_engine.sv
// Bash echo command: buffers one terminal line and writes it back REPEAT times.
// Define ECHO_LINE_NUMBER_EN to prefix each echoed line with "<n>:".
module echo_engine
  import echo_pkg::*;
#(
  parameter int unsigned MAX_LEN = 32,
  parameter int unsigned LEN_W   = 6,
  parameter int unsigned REPEAT  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  output logic             in_solved,
  input  logic             out_solved,
  output logic             in_require_line,
  input  logic             out_require_line,
  input  logic             lineIn_nextASCII,
  output logic             in_newASCII_ready,
  output logic [7:0]       lineIn,
  output logic             lineOut_nextASCII,
  input  logic             out_newASCII_ready,
  input  logic [LEN_W-1:0] out_lineLen,
  input  logic [7:0]       lineOut,
  output logic             overflow
);

  localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  state_e                state_q, state_d;
  logic [LEN_W-1:0]      len_q, len_d, rd_idx_q, rd_idx_d, rd_ptr;
  logic [LINE_CNT_W-1:0] line_cnt_q, line_cnt_d;
  logic [1:0]            mode_q, mode_d;
  logic                  take_q, take_d, req_q, req_d;
  logic                  solved_q, solved_d, ovf_q, ovf_d;
  logic                  wr_en, got_char, got_term, emit_go, line_end, last_line;
  logic                  in_prefix;
  logic [7:0]            buf_q [MAX_LEN];
  logic [7:0]            rd_char, xf_char, pfx_char;
  logic                  unused_len;

  // Reported length is informational; framing relies on the terminator.
  assign unused_len = ^out_lineLen;

  assign got_char  = take_q && ((state_q == RECV) || (state_q == REQ));
  assign got_term  = got_char && (lineOut == NUL);
  assign emit_go   = (state_q == EMIT) && !out_newASCII_ready;
  assign line_end  = emit_go && !in_prefix && (rd_idx_q == len_q);
  assign last_line = (line_cnt_q == LINE_CNT_W'(REPEAT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RECV;
    else        state_q <= state_d;
  end

  // Next state; an acknowledge coinciding with entry skips the wait state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RECV: if (got_term) state_d = EMIT;
      REQ: begin
        if (got_term)              state_d = EMIT;
        else if (out_require_line) state_d = RECV;
      end
      EMIT: if (line_end) begin
        if (last_line) state_d = out_solved ? RECV : DONE;
        else           state_d = out_require_line ? RECV : REQ;
      end
      DONE: if (out_solved) state_d = RECV;
      default: state_d = RECV;
    endcase
  end

  always_comb begin
    len_d      = len_q;
    rd_idx_d   = rd_idx_q;
    line_cnt_d = line_cnt_q;
    mode_d     = mode_q;
    take_d     = 1'b0;
    req_d      = req_q;
    solved_d   = solved_q;
    ovf_d      = ovf_q;
    wr_en      = 1'b0;
    unique case (state_q)
      RECV, REQ: begin
        take_d = out_newASCII_ready && !take_q;
        if ((state_q == REQ) && out_require_line) req_d = 1'b0;
        if (got_term) begin
          mode_d   = ((mode == MODE_UPPER) || (mode == MODE_REV)) ? mode : MODE_PLAIN;
          rd_idx_d = '0;
          req_d    = 1'b0;
        end else if (got_char) begin
          if (len_q < LEN_W'(MAX_LEN)) begin
            wr_en = 1'b1;
            len_d = len_q + LEN_W'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      EMIT: begin
        if (emit_go && !in_prefix && !line_end && lineIn_nextASCII) begin
          rd_idx_d = rd_idx_q + LEN_W'(1);
        end
        if (line_end) begin
          len_d      = '0;
          rd_idx_d   = '0;
          line_cnt_d = line_cnt_q + LINE_CNT_W'(1);
          if (!last_line) begin
            req_d = !out_require_line;
          end else if (out_solved) begin
            line_cnt_d = '0;
            ovf_d      = 1'b0;
          end else begin
            solved_d = 1'b1;
          end
        end
      end
      DONE: begin
        line_cnt_d = '0;
        if (out_solved) begin
          solved_d = 1'b0;
          ovf_d    = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q      <= '0;
      rd_idx_q   <= '0;
      line_cnt_q <= '0;
      mode_q     <= MODE_PLAIN;
      take_q     <= 1'b0;
      req_q      <= 1'b0;
      solved_q   <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      len_q      <= len_d;
      rd_idx_q   <= rd_idx_d;
      line_cnt_q <= line_cnt_d;
      mode_q     <= mode_d;
      take_q     <= take_d;
      req_q      <= req_d;
      solved_q   <= solved_d;
      ovf_q      <= ovf_d;
    end
  end

  // Line storage carries no reset; only len_q qualifies its contents.
  always_ff @(posedge clk) begin
    if (wr_en) buf_q[AW'(len_q)] <= lineOut;
  end

  assign rd_ptr  = (mode_q == MODE_REV) ? (len_q - rd_idx_q - LEN_W'(1)) : rd_idx_q;
  assign rd_char = buf_q[AW'(rd_ptr)];

  echo_char_xform u_xform (
    .upper_en_i (mode_q == MODE_UPPER),
    .char_i     (rd_char),
    .char_c_o   (xf_char)
  );

`ifdef ECHO_LINE_NUMBER_EN
  logic [1:0] pfx_q, pfx_d;

  always_comb begin
    pfx_d = pfx_q;
    if (state_q != EMIT)                             pfx_d = '0;
    else if (emit_go && in_prefix && lineIn_nextASCII) pfx_d = pfx_q + 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pfx_q <= '0;
    else        pfx_q <= pfx_d;
  end

  assign in_prefix = (pfx_q != 2'd2);
  assign pfx_char  = (pfx_q == 2'd0) ? (DIGIT0 + 8'(line_cnt_q) + 8'd1) : COLON;
`else
  assign in_prefix = 1'b0;
  assign pfx_char  = NUL;
`endif

  // Screen-side character is decoded from registered state and buffer.
  always_comb begin
    lineIn = NUL;
    if (state_q == EMIT) begin
      if (in_prefix)              lineIn = pfx_char;
      else if (rd_idx_q != len_q) lineIn = xf_char;
    end
  end

  assign in_newASCII_ready = emit_go;
  assign lineOut_nextASCII = take_q;
  assign in_require_line   = req_q;
  assign in_solved         = solved_q;
  assign overflow          = ovf_q;

endmodule

// File: tb/tb_echo_engine.sv
// Randomised bench for echo_engine against a queue-based line echo model.
module tb_echo_engine;

  localparam int unsigned MAX_LEN = 4;
  localparam int unsigned LEN_W   = 3;
  localparam int unsigned REPEAT  = 3;

  typedef byte unsigned bq_t[$];

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       mode;
  logic             in_solved, out_solved;
  logic             in_require_line, out_require_line;
  logic             lineIn_nextASCII, in_newASCII_ready;
  logic [7:0]       lineIn;
  logic             lineOut_nextASCII, out_newASCII_ready;
  logic [LEN_W-1:0] out_lineLen;
  logic [7:0]       lineOut;
  logic             overflow;

  int n_tests  = 0;
  int n_fail   = 0;
  int req_seen = 0;
  bit ovf_cmd  = 1'b0;

  always #5 clk = ~clk;

  echo_engine #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .REPEAT(REPEAT)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .mode               (mode),
    .in_solved          (in_solved),
    .out_solved         (out_solved),
    .in_require_line    (in_require_line),
    .out_require_line   (out_require_line),
    .lineIn_nextASCII   (lineIn_nextASCII),
    .in_newASCII_ready  (in_newASCII_ready),
    .lineIn             (lineIn),
    .lineOut_nextASCII  (lineOut_nextASCII),
    .out_newASCII_ready (out_newASCII_ready),
    .out_lineLen        (out_lineLen),
    .lineOut            (lineOut),
    .overflow           (overflow)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bq_t str2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  function automatic bq_t rand_line();
    bq_t q;
    int n = $urandom_range(0, 6);
    for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(1, 255)));
    return q;
  endfunction

  // Screen side streaming a line (plus terminator) into the engine.
  task automatic send_line(input bq_t s, output int pulses, output bit ok);
    bq_t q = s;
    int  idx = 0;
    bit  pending = 1'b0;
    q.push_back(8'h00);
    pulses = 0;
    ok = 1'b0;
    out_lineLen = LEN_W'(s.size());
    out_newASCII_ready = 1'b1;
    lineOut = q[0];
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (pending) begin
        pending = 1'b0;
        idx++;
        if (idx < q.size()) lineOut = q[idx];
        else begin
          out_newASCII_ready = 1'b0;
          lineOut = 8'h00;
          ok = 1'b1;
          break;
        end
      end
      if (lineOut_nextASCII) begin
        pulses++;
        pending = 1'b1;
      end
    end
    out_newASCII_ready = 1'b0;
  endtask

  // Screen side consuming the echoed line with random stalls.
  task automatic collect_line(output bq_t got, output int term_cycles, output bit ok);
    bit seen_term = 1'b0;
    bit stall;
    got.delete();
    term_cycles = 0;
    ok = 1'b0;
    #1;
    check_eq("first_char_latency", 32'(in_newASCII_ready), 32'd1);
    for (int c = 0; c < 200; c++) begin
      if (in_newASCII_ready) begin
        if (lineIn == 8'h00) begin
          if (!seen_term) got.push_back(8'h00);
          seen_term = 1'b1;
          term_cycles++;
          lineIn_nextASCII = 1'b0;
        end else begin
          stall = ($urandom_range(0, 3) == 0);
          lineIn_nextASCII = !stall;
          if (!stall) got.push_back(lineIn);
        end
      end else begin
        lineIn_nextASCII = 1'b0;
        if (seen_term) begin
          ok = 1'b1;
          break;
        end
      end
      @(negedge clk);
    end
    lineIn_nextASCII = 1'b0;
  endtask

  // One input line: stream, check echo against the model, then handshake.
  task automatic do_line(input bq_t s, input logic [1:0] m, input int ln);
    bq_t body, exp, got;
    int  pulses, term_cycles, n, waitc;
    bit  ok;
    n = (s.size() < int'(MAX_LEN)) ? s.size() : int'(MAX_LEN);
    for (int i = 0; i < n; i++) begin
      byte unsigned ch;
      ch = s[i];
      if (m == 2'd1 && ch >= 8'h61 && ch <= 8'h7A) ch = ch - 8'h20;
      if (m == 2'd2) body.push_front(ch);
      else           body.push_back(ch);
    end
`ifdef ECHO_LINE_NUMBER_EN
    exp.push_back(8'(8'h31 + ln));
    exp.push_back(8'h3A);
`endif
    foreach (body[i]) exp.push_back(body[i]);
    exp.push_back(8'h00);
    if (s.size() > int'(MAX_LEN)) ovf_cmd = 1'b1;

    mode = m;
    send_line(s, pulses, ok);
    mode = 2'($urandom);
    check_eq("send_done", 32'(ok), 32'd1);
    check_eq("rx_pulses", pulses, s.size() + 1);

    collect_line(got, term_cycles, ok);
    check_eq("emit_done", 32'(ok), 32'd1);
    check_eq("emit_len", got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      check_eq($sformatf("emit_char[%0d]", i), 32'(got[i]), 32'(exp[i]));
    end
    check_eq("term_cycles", term_cycles, 1);
    check_eq("overflow", 32'(overflow), 32'(ovf_cmd));

    waitc = $urandom_range(0, 2);
    if (ln < int'(REPEAT) - 1) begin
      check_eq("req_set", 32'(in_require_line), 32'd1);
      check_eq("solved_idle", 32'(in_solved), 32'd0);
      if (in_require_line) req_seen++;
      repeat (waitc) @(negedge clk);
      check_eq("req_held", 32'(in_require_line), 32'd1);
      out_require_line = 1'b1;
      @(negedge clk);
      out_require_line = 1'b0;
      check_eq("req_clr", 32'(in_require_line), 32'd0);
    end else begin
      check_eq("solved_set", 32'(in_solved), 32'd1);
      check_eq("req_idle", 32'(in_require_line), 32'd0);
      repeat (waitc) @(negedge clk);
      check_eq("solved_held", 32'(in_solved), 32'd1);
      out_solved = 1'b1;
      @(negedge clk);
      out_solved = 1'b0;
      check_eq("solved_clr", 32'(in_solved), 32'd0);
      check_eq("ovf_clr", 32'(overflow), 32'd0);
      ovf_cmd = 1'b0;
    end
  endtask

  initial begin
    int  pulses;
    bit  ok;
    rst_n = 1'b0;
    mode = 2'd0;
    out_solved = 1'b0;
    out_require_line = 1'b0;
    lineIn_nextASCII = 1'b0;
    out_newASCII_ready = 1'b0;
    out_lineLen = '0;
    lineOut = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("reset_outs", 32'({in_solved, in_require_line, in_newASCII_ready,
                                lineIn, lineOut_nextASCII, overflow}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // plain echo repeated three times
    req_seen = 0;
    for (int ln = 0; ln < int'(REPEAT); ln++) do_line(str2q("ab"), 2'd0, ln);
    check_eq("req_pulses", req_seen, int'(REPEAT) - 1);

    do_line(str2q("aZ9"), 2'd1, 0);
    do_line(str2q("xyz"), 2'd2, 1);
    do_line(str2q("abcdef"), 2'd0, 2);

    // overflow stays sticky across the rest of the command
    do_line(str2q("abcde"), 2'd2, 0);
    do_line(str2q("`{az"), 2'd1, 1);
    do_line(str2q(""), 2'd0, 2);

    do_line(str2q("AbC"), 2'd3, 0);
    do_line(str2q(""), 2'd1, 1);
    do_line(str2q("z"), 2'd2, 2);

    // asynchronous reset in the middle of an echo
    mode = 2'd0;
    send_line(str2q("abcdef"), pulses, ok);
    check_eq("rst_send_done", 32'(ok), 32'd1);
    #1 lineIn_nextASCII = 1'b1;
    @(negedge clk);
    lineIn_nextASCII = 1'b0;
    check_eq("pre_rst_ready", 32'(in_newASCII_ready), 32'd1);
`ifdef ECHO_LINE_NUMBER_EN
    check_eq("pre_rst_char", 32'(lineIn), 32'h3A);
`else
    check_eq("pre_rst_char", 32'(lineIn), 32'h62);
`endif
    check_eq("pre_rst_ovf", 32'(overflow), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_eq("async_rst_outs", 32'({in_solved, in_require_line, in_newASCII_ready,
                                       lineIn, lineOut_nextASCII, overflow}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ovf_cmd = 1'b0;
    @(negedge clk);
    do_line(str2q("q"), 2'd0, 0);
    do_line(rand_line(), 2'($urandom), 1);
    do_line(rand_line(), 2'($urandom), 2);

    for (int c = 0; c < 8; c++) begin
      for (int ln = 0; ln < int'(REPEAT); ln++) do_line(rand_line(), 2'($urandom), ln);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/echo_engine.md
Name: echo_engine

Overview:
- Parametrised bash-command echo block between the video-memory line interface and the command layer.
- Reads one terminal line (00-terminated) into a line buffer, then writes it back to the screen REPEAT times.
- Between repetitions it requests a fresh input line; after the last one it raises a solved flag.
- Adds over the fixed-size echo: configurable depth and repeat count, runtime transform mode, overflow detection, and a line-number prefix option.

Parameters:
- MAX_LEN, 32: line-buffer depth in characters, terminator excluded.
- LEN_W, 6: width of length/index counters; must satisfy 2^LEN_W > MAX_LEN.
- REPEAT, 3: input lines echoed per command, 1..15.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- mode  in  2  transform: 0 plain, 1 uppercase, 2 reversed, 3 treated as 0. Sampled on RECV→EMIT.
- in_solved  out  1  command finished; held until out_solved.
- out_solved  in  1  one-cycle acknowledge of in_solved.
- in_require_line  out  1  requests another input line; held until out_require_line.
- out_require_line  in  1  one-cycle acknowledge of in_require_line.
- lineIn_nextASCII  in  1  screen consumed current lineIn character.
- in_newASCII_ready  out  1  output line in progress.
- lineIn  out  8  character to screen; 8'h00 terminates.
- lineOut_nextASCII  out  1  one-cycle pulse: current lineOut character taken.
- out_newASCII_ready  in  1  input line still streaming.
- out_lineLen  in  LEN_W  reported input length; informational only.
- lineOut  in  8  character from screen.
- overflow  out  1  sticky: input exceeded MAX_LEN during this command.

Behaviour:
- Reset (async, any state): all outputs 0, state RECV, len/rd_idx/line_cnt 0, buffer contents don't-care.
- States: RECV, EMIT, REQ, DONE.
- RECV:
  - When out_newASCII_ready=1 and lineOut_nextASCII=0, pulse lineOut_nextASCII for exactly one cycle. The next cycle has it 0, so each character takes 2 cycles.
  - Character ≠ 0 and len<MAX_LEN: store at buffer[len], len++.
  - Character ≠ 0 and len==MAX_LEN: drop it, set overflow.
  - Character == 0: latch mode, rd_idx←0, go to EMIT.
- Output gate: in_newASCII_ready is asserted, and EMIT advances, only while out_newASCII_ready=0.
- EMIT:
  - in_newASCII_ready=1.
  - lineIn = xform(buffer[idx]) while rd_idx<len, else 8'h00. idx = rd_idx (modes 0/1) or len-1-rd_idx (mode 2).
  - Uppercase: 8'h61..8'h7A minus 8'h20; all other characters unchanged.
  - lineIn_nextASCII with rd_idx<len: rd_idx++.
  - rd_idx==len: next cycle in_newASCII_ready←0, len←0, line_cnt++. Go to DONE if line_cnt==REPEAT-1, else REQ.
- Empty line (len 0): EMIT emits the terminator only, for one cycle, and still counts as a line.
- REQ: in_require_line=1; on out_require_line, clear it and go to RECV. Input arriving during REQ is accepted as in RECV.
- DONE: in_solved=1, line_cnt←0; on out_solved, clear in_solved and overflow, go to RECV.
- Simultaneous acknowledge and state-entry in the same cycle: the acknowledge wins (flag stays 0).
- Latency: first output character is valid 1 cycle after the terminator is consumed.

Optional Feature:
- Macro ECHO_LINE_NUMBER_EN.
- Defined: each emitted line is prefixed with the ASCII digit of line_cnt+1 (8'h31+line_cnt) then ':' (8'h3A). Each prefix character advances on lineIn_nextASCII before the buffer contents; requires REPEAT≤9.
- Undefined: no prefix, identical to the above behaviour.

Decomposition:
- Package echo_pkg:
  - state enum {RECV, EMIT, REQ, DONE};
  - mode constants MODE_PLAIN/UPPER/REV;
  - ASCII constants NUL, COLON, DIGIT0, LOWER_A, LOWER_Z, CASE_DELTA.
- Sub-module echo_char_xform: combinational uppercase mapping, instantiated once on the buffer read data.

Test Plan:
- mode 0, REPEAT=3, input "ab" 3 times:
  - lineIn sequence 61,62,00 per line;
  - in_require_line pulses twice;
  - in_solved after third line, clears one cycle after out_solved.
- mode 1, input "aZ9" → 41,5A,39,00.
- mode 2, input "xyz" → 7A,79,78,00.
- MAX_LEN=4, input "abcdef":
  - only 61..64 echoed;
  - overflow=1 until out_solved;
  - lineOut_nextASCII pulses 7 times.
- Empty line: single cycle of lineIn=00 with in_newASCII_ready=1; line_cnt advances.
- rst_n low mid-EMIT:
  - all outputs 0 immediately (asynchronous);
  - after release, next line "q" echoes 71,00 as line 1.
